ysyx_25040111_wbarb: RTL and testbench

- Writeback arbiter and register scoreboard for the 16-entry RV32E register file, which has one write port with same-cycle write-to-read forwarding.
- Shares the single write port between two producers: EXU (ALU/CSR results) and LSU (load returns).
- Tracks which destination registers have results still in flight, and stalls issue on RAW and WAW hazards.
- Sits between the IDU issue point, the EXU/LSU result paths and the register file write port.

---
 rtl/ysyx_25040111_wbarb_pkg.sv | 8 +
 rtl/ysyx_25040111_rr_arb2.sv | 26 ++
 rtl/ysyx_25040111_wbarb.sv | 70 +++++++
 tb/tb_ysyx_25040111_wbarb.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_wbarb_pkg.sv
// ysyx_25040111_wbarb_pkg: shared sizes and grant encoding for the writeback arbiter.
package ysyx_25040111_wbarb_pkg;
   localparam int NREG_DEF = 16;
   localparam int AW_DEF   = 4;
   localparam int DW_DEF   = 32;
   localparam logic GNT_EXU = 1'b0;
   localparam logic GNT_LSU = 1'b1;
endpackage

// File: rtl/ysyx_25040111_rr_arb2.sv
// ysyx_25040111_rr_arb2: two-way round-robin arbiter (req[0]=EXU, req[1]=LSU).
// YSYX_25040111_WBARB_LSU_PRIO_EN selects fixed LSU priority instead.
module ysyx_25040111_rr_arb2
   import ysyx_25040111_wbarb_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   output logic       gnt_valid,
   output logic       gnt_sel
);
   logic last_gnt_q, last_gnt_d;
   always_comb begin
`ifdef YSYX_25040111_WBARB_LSU_PRIO_EN
      gnt_sel = req[1];
`else
      gnt_sel = req[1] && (!req[0] || last_gnt_q == GNT_EXU);
`endif
      gnt_valid  = |req;
      last_gnt_d = gnt_valid ? gnt_sel : last_gnt_q;
   end
   always_ff @(posedge clock) begin
      if (!reset) last_gnt_q <= GNT_LSU;
      else        last_gnt_q <= last_gnt_d;
   end
endmodule

// File: rtl/ysyx_25040111_wbarb.sv
// ysyx_25040111_wbarb: writeback arbiter and RAW/WAW scoreboard for a 16-entry register file.
// YSYX_25040111_WBARB_LSU_PRIO_EN gives the LSU fixed priority on write-port conflicts.
module ysyx_25040111_wbarb
   import ysyx_25040111_wbarb_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          iss_valid,
   input  logic [1:0]    iss_ren,
   input  logic [AW-1:0] iss_rs1,
   input  logic [AW-1:0] iss_rs2,
   input  logic          iss_wen,
   input  logic [AW-1:0] iss_rd,
   output logic          iss_stall,
   input  logic          exu_valid,
   input  logic [AW-1:0] exu_rd,
   input  logic [DW-1:0] exu_data,
   output logic          exu_ready,
   input  logic          lsu_valid,
   input  logic [AW-1:0] lsu_rd,
   input  logic [DW-1:0] lsu_data,
   output logic          lsu_ready,
   output logic          rf_wen,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic          busy,
   output logic          err
);
   logic [NREG-1:0] pending_q, pending_d, clr_vec, set_vec, pend_eff;
   logic            err_q, err_d;
   logic            gnt_valid, gnt_sel, set_en;
   ysyx_25040111_rr_arb2 u_arb (
      .clock     (clock),
      .reset     (reset),
      .req       ({lsu_valid && reset, exu_valid && reset}),
      .gnt_valid (gnt_valid),
      .gnt_sel   (gnt_sel)
   );
   always_comb begin
      exu_ready = gnt_valid && gnt_sel == GNT_EXU;
      lsu_ready = gnt_valid && gnt_sel == GNT_LSU;
      rf_waddr  = gnt_sel == GNT_LSU ? lsu_rd : exu_rd;
      rf_wdata  = gnt_sel == GNT_LSU ? lsu_data : exu_data;
      rf_wen    = gnt_valid && rf_waddr != '0;
      clr_vec   = rf_wen ? {{(NREG-1){1'b0}}, 1'b1} << rf_waddr : '0;
      // The register being written this cycle is forwarded by the register file, so it no longer blocks.
      pend_eff  = pending_q & ~clr_vec;
      iss_stall = !reset || (iss_valid && ((iss_ren[0] && pend_eff[iss_rs1]) ||
                  (iss_ren[1] && pend_eff[iss_rs2]) || (iss_wen && pend_eff[iss_rd])));
      set_en    = iss_valid && !iss_stall && iss_wen && iss_rd != '0;
      set_vec   = set_en ? {{(NREG-1){1'b0}}, 1'b1} << iss_rd : '0;
      pending_d = (pend_eff | set_vec) & ~{{(NREG-1){1'b0}}, 1'b1};
      err_d     = err_q || (gnt_valid && rf_waddr != '0 && !pending_q[rf_waddr]);
      busy      = reset && |pending_q;
      err       = err_q;
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         pending_q <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         err_q     <= err_d;
      end
   end
endmodule

// File: tb/tb_ysyx_25040111_wbarb.sv
// tb_ysyx_25040111_wbarb: directed self-checking bench for the writeback arbiter.
module tb_ysyx_25040111_wbarb;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        iss_valid = 1'b0;
   logic [1:0]  iss_ren = 2'd0;
   logic [3:0]  iss_rs1 = 4'd0, iss_rs2 = 4'd0, iss_rd = 4'd0;
   logic        iss_wen = 1'b0;
   logic        iss_stall;
   logic        exu_valid = 1'b0, lsu_valid = 1'b0;
   logic [3:0]  exu_rd = 4'd0, lsu_rd = 4'd0;
   logic [31:0] exu_data = 32'd0, lsu_data = 32'd0;
   logic        exu_ready, lsu_ready, rf_wen, busy, err;
   logic [3:0]  rf_waddr;
   logic [31:0] rf_wdata;
   int          checks = 0;
   int          failures = 0;
   logic [3:0]  first_a, second_a;

   ysyx_25040111_wbarb dut (
      .clock(clock), .reset(reset),
      .iss_valid(iss_valid), .iss_ren(iss_ren), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_wen(iss_wen), .iss_rd(iss_rd), .iss_stall(iss_stall),
      .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .err(err)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] rd);
      iss_valid = 1'b1; iss_ren = 2'd0; iss_wen = 1'b1; iss_rd = rd;
      #1;
      chk("issue_nostall", iss_stall, 0);
      step();
      iss_valid = 1'b0; iss_wen = 1'b0;
   endtask

   initial begin
`ifdef YSYX_25040111_WBARB_LSU_PRIO_EN
      first_a = 4'd4; second_a = 4'd3;
`else
      first_a = 4'd3; second_a = 4'd4;
`endif
      exu_valid = 1'b1; exu_rd = 4'd3; iss_valid = 1'b1;
      step(); step();
      chk("rst_stall", iss_stall, 1);
      chk("rst_busy", busy, 0);
      chk("rst_exu_ready", exu_ready, 0);
      chk("rst_rf_wen", rf_wen, 0);
      reset = 1'b1; exu_valid = 1'b0; iss_valid = 1'b0;
      step();
      chk("rel_busy", busy, 0);
      chk("rel_err", err, 0);
      iss_valid = 1'b1; iss_ren = 2'd3; iss_rs1 = 4'd5; iss_rs2 = 4'd6;
      #1;
      chk("rel_stall", iss_stall, 0);
      iss_valid = 1'b0;
      // conflict A with last_gnt at its reset value
      issue(4'd3); issue(4'd4); issue(4'd10);
      chk("pend_busy", busy, 1);
      exu_valid = 1'b1; exu_rd = 4'd3; exu_data = 32'h33;
      lsu_valid = 1'b1; lsu_rd = 4'd4; lsu_data = 32'h44;
      #1;
      chk("confA_first", rf_waddr, first_a);
      chk("confA_wen", rf_wen, 1);
      step();
      if (first_a == 4'd3) exu_valid = 1'b0; else lsu_valid = 1'b0;
      #1;
      chk("confA_second", rf_waddr, second_a);
      step();
      exu_valid = 1'b0; lsu_valid = 1'b0;
      exu_valid = 1'b1; exu_rd = 4'd10; exu_data = 32'hA;
      #1;
      chk("solo_exu_ready", exu_ready, 1);
      step();
      exu_valid = 1'b0;
      // conflict B after an EXU grant: LSU wins in either build
      issue(4'd3); issue(4'd4);
      exu_valid = 1'b1; exu_rd = 4'd3; lsu_valid = 1'b1; lsu_rd = 4'd4; lsu_data = 32'h4444;
      #1;
      chk("confB_first", rf_waddr, 4);
      chk("confB_lsu_ready", lsu_ready, 1);
      chk("confB_wdata", rf_wdata, 32'h4444);
      step();
      lsu_valid = 1'b0;
      #1;
      chk("confB_second", rf_waddr, 3);
      step();
      exu_valid = 1'b0;
      #1;
      chk("confB_idle", busy, 0);
      // RAW on r5 with bypass
      issue(4'd5);
      iss_valid = 1'b1; iss_ren = 2'd1; iss_rs1 = 4'd5;
      #1;
      chk("raw_stall", iss_stall, 1);
      exu_valid = 1'b1; exu_rd = 4'd5; exu_data = 32'hDEADBEEF;
      #1;
      chk("raw_wen", rf_wen, 1);
      chk("raw_waddr", rf_waddr, 5);
      chk("raw_wdata", rf_wdata, 32'hDEADBEEF);
      chk("raw_bypass", iss_stall, 0);
      step();
      exu_valid = 1'b0;
      #1;
      chk("raw_cleared", iss_stall, 0);
      chk("raw_busy", busy, 0);
      iss_valid = 1'b0; iss_ren = 2'd0;
      // WAW on r7 and set-wins-over-clear
      issue(4'd7);
      iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 4'd7;
      #1;
      chk("waw_stall", iss_stall, 1);
      exu_valid = 1'b1; exu_rd = 4'd7;
      #1;
      chk("waw_bypass", iss_stall, 0);
      step();
      exu_valid = 1'b0; iss_wen = 1'b0; iss_ren = 2'd1; iss_rs1 = 4'd7;
      #1;
      chk("setwins_stall", iss_stall, 1);
      chk("setwins_busy", busy, 1);
      chk("setwins_err", err, 0);
      iss_valid = 1'b0; iss_ren = 2'd0;
      lsu_valid = 1'b1; lsu_rd = 4'd7;
      step();
      lsu_valid = 1'b0;
      #1;
      chk("r7_drain", busy, 0);
      // writebacks to r0 and to a non-pending register
      exu_valid = 1'b1; exu_rd = 4'd0;
      #1;
      chk("r0_ready", exu_ready, 1);
      chk("r0_wen", rf_wen, 0);
      step();
      chk("r0_err", err, 0);
      exu_rd = 4'd9;
      step();
      exu_valid = 1'b0;
      #1;
      chk("err_set", err, 1);
      step();
      chk("err_sticky", err, 1);
      // reset with r2 pending and the LSU holding a result
      issue(4'd2);
      chk("r2_busy", busy, 1);
      lsu_valid = 1'b1; lsu_rd = 4'd2; reset = 1'b0;
      #1;
      chk("mid_rst_lsu_ready", lsu_ready, 0);
      chk("mid_rst_wen", rf_wen, 0);
      chk("mid_rst_stall", iss_stall, 1);
      chk("mid_rst_busy", busy, 0);
      step(); step();
      chk("in_rst_lsu_ready", lsu_ready, 0);
      reset = 1'b1; lsu_valid = 1'b0;
      step();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_err", err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
